impulse_conditioner: RTL and testbench

IMPULSE_CONDITIONER -- requirements
Module: impulse_conditioner

---
 rtl/impulse_conditioner.sv | 112 +++++++++++
 tb/tb_impulse_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/impulse_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : impulse_conditioner
//  Purpose  : Synchronizes, debounces and edge-detects eight impulse channels
//             plus one RTC reference line. Produces one-cycle pulses on
//             accepted rising edges and sticky glitch flags that the RTC tick
//             clears.
//  Revision : 1.0 - initial release
// ============================================================================
module impulse_conditioner #(
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ch_in,
    input  logic       rtc_in,
    input  logic [7:0] ch_mask,
    output logic [7:0] ch_pulse,
    output logic       rtc_tick,
    output logic [7:0] ch_level,
    output logic [7:0] glitch_flag
);

    // Lines 0..7 are the impulse channels, line 8 is the RTC reference.
    localparam int         c_NLINES  = 9;
    localparam int         c_NCH     = 8;
    localparam logic [4:0] c_CNT_MAX = 5'(FILT_LEN - 1);

    logic [8:0] r_s1_q;
    logic [8:0] r_s2_q;
    logic [8:0] r_level_q;
    logic [8:0] w_level_d;
    logic [4:0] r_cnt_q [c_NLINES];
    logic [4:0] w_cnt_d [c_NLINES];
    logic [8:0] w_rise;
    logic [7:0] w_glitch;
    logic [7:0] r_pulse_q;
    logic [7:0] w_pulse_d;
    logic       r_tick_q;
    logic       w_tick_d;
    logic [7:0] r_gflag_q;
    logic [7:0] w_gflag_d;

    // Persistence filter: a new level is accepted only after s2 has differed
    // from it for FILT_LEN consecutive edges; acceptance and clear share an edge.
    always_comb begin
        w_level_d = r_level_q;
        w_rise    = '0;
        for (int i = 0; i < c_NLINES; i++) begin
            w_cnt_d[i] = r_cnt_q[i];
            if (r_s2_q[i] != r_level_q[i]) begin
                if (r_cnt_q[i] == c_CNT_MAX) begin
                    w_level_d[i] = r_s2_q[i];
                    w_cnt_d[i]   = 5'd0;
                    w_rise[i]    = r_s2_q[i];
                end else begin
                    w_cnt_d[i] = r_cnt_q[i] + 5'd1;
                end
            end else begin
                w_cnt_d[i] = 5'd0;
            end
        end
    end

    // A glitch is a partial count abandoned because s2 returned to the level;
    // only the impulse channels report it, never the RTC line.
    always_comb begin
        w_glitch = '0;
        for (int i = 0; i < c_NCH; i++) begin
            w_glitch[i] = (r_s2_q[i] == r_level_q[i]) && (r_cnt_q[i] != 5'd0);
        end
    end

    // Pulse, tick and sticky-flag next state; a new glitch beats the RTC clear.
    always_comb begin
        w_pulse_d = w_rise[7:0] & ch_mask;
        w_tick_d  = w_rise[8];
        w_gflag_d = w_glitch | (r_gflag_q & ~{c_NCH{w_rise[8]}});
    end

    // State registers: synchronizers, filters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_q    <= '0;
            r_s2_q    <= '0;
            r_level_q <= '0;
            r_pulse_q <= '0;
            r_tick_q  <= 1'b0;
            r_gflag_q <= '0;
            for (int i = 0; i < c_NLINES; i++) begin
                r_cnt_q[i] <= 5'd0;
            end
        end else begin
            r_s1_q    <= {rtc_in, ch_in};
            r_s2_q    <= r_s1_q;
            r_level_q <= w_level_d;
            r_pulse_q <= w_pulse_d;
            r_tick_q  <= w_tick_d;
            r_gflag_q <= w_gflag_d;
            for (int i = 0; i < c_NLINES; i++) begin
                r_cnt_q[i] <= w_cnt_d[i];
            end
        end
    end

    assign ch_pulse    = r_pulse_q;
    assign rtc_tick    = r_tick_q;
    assign ch_level    = r_level_q[7:0];
    assign glitch_flag = r_gflag_q;

endmodule
`default_nettype wire

// File: tb/tb_impulse_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_impulse_conditioner
//  Purpose  : Directed self-checking bench for impulse_conditioner with a
//             pulse scoreboard (expected pulse events queued at stimulus time).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_impulse_conditioner;

    localparam int c_FILT = 4;
    // Drive at negedge n -> s1 capture at edge n+1 -> level/pulse at edge
    // n+2+FILT_LEN, observed at the following negedge.
    localparam int c_LAT  = c_FILT + 2;

    typedef struct {
        int         cyc;
        logic [7:0] pulse;
        logic       tick;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ch_in;
    logic       rtc_in;
    logic [7:0] ch_mask;
    logic [7:0] ch_pulse;
    logic       rtc_tick;
    logic [7:0] ch_level;
    logic [7:0] glitch_flag;

    int  cyc = 0;
    int  tests_run = 0;
    int  tests_failed = 0;
    ev_t sb[$];

    impulse_conditioner #(.FILT_LEN(c_FILT)) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_in      (ch_in),
        .rtc_in     (rtc_in),
        .ch_mask    (ch_mask),
        .ch_pulse   (ch_pulse),
        .rtc_tick   (rtc_tick),
        .ch_level   (ch_level),
        .glitch_flag(glitch_flag)
    );

    always #5 clk = ~clk;

    // Edge counter used to timestamp expected and observed pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every nonzero pulse/tick cycle must match the queue head.
    always @(negedge clk) begin
        ev_t e;
        bit  have;
        if (!reset && (ch_pulse !== 8'h00 || rtc_tick !== 1'b0)) begin
            tests_run++;
            have = (sb.size() != 0);
            if (have) e = sb.pop_front();
            else      e = '{-1, 8'h00, 1'b0};
            assert (have && cyc == e.cyc && ch_pulse === e.pulse && rtc_tick === e.tick)
            else begin
                tests_failed++;
                $error("FAIL pulse_event: observed cyc=%0d pulse=%0h tick=%0b expected cyc=%0d pulse=%0h tick=%0b (queued=%0b)",
                       cyc, ch_pulse, rtc_tick, e.cyc, e.pulse, e.tick, have);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int dly, input logic [7:0] p, input logic t);
        sb.push_back('{cyc + dly, p, t});
    endtask

    initial begin
        reset   = 1'b1;
        ch_in   = 8'h00;
        rtc_in  = 1'b0;
        ch_mask = 8'hFF;
        step(3);
        check("rst_pulse", 32'(ch_pulse), 32'h0);
        check("rst_tick",  32'(rtc_tick), 32'h0);
        check("rst_level", 32'(ch_level), 32'h0);
        check("rst_gflag", 32'(glitch_flag), 32'h0);
        reset = 1'b0;
        step(3);

        // Single accepted rise on channel 1 (bit 0), then a falling edge.
        ch_in[0] = 1'b1;
        expect_ev(c_LAT, 8'h01, 1'b0);
        step(c_LAT - 1);
        check("lvl0_before", 32'(ch_level), 32'h00);
        step(1);
        check("lvl0_accept", 32'(ch_level), 32'h01);
        step(2);
        check("lvl0_hold", 32'(ch_level), 32'h01);
        ch_in[0] = 1'b0;
        step(8);
        check("lvl0_fall", 32'(ch_level), 32'h00);
        check("no_gflag_clean", 32'(glitch_flag), 32'h00);

        // Two-cycle glitch on bit 3, then an RTC tick clears the flag.
        ch_in[3] = 1'b1;
        step(2);
        ch_in[3] = 1'b0;
        step(8);
        check("glitch3_flag",  32'(glitch_flag), 32'h08);
        check("glitch3_level", 32'(ch_level), 32'h00);
        rtc_in = 1'b1;
        expect_ev(c_LAT, 8'h00, 1'b1);
        step(c_LAT - 1);
        check("gflag_before_tick", 32'(glitch_flag), 32'h08);
        step(1);
        check("gflag_cleared", 32'(glitch_flag), 32'h00);
        rtc_in = 1'b0;
        step(8);

        // All channels rise together under mask A5; unmasking adds no pulse.
        ch_mask = 8'hA5;
        ch_in   = 8'hFF;
        expect_ev(c_LAT, 8'hA5, 1'b0);
        step(c_LAT);
        check("all_level", 32'(ch_level), 32'hFF);
        step(1);
        ch_mask = 8'hFF;
        step(4);
        ch_in = 8'h00;
        step(8);
        check("all_fall", 32'(ch_level), 32'h00);

        // Reset two cycles into filtering of bit 5; input still high at release.
        ch_in[5] = 1'b1;
        step(3);
        reset = 1'b1;
        #1;
        check("midrst_level", 32'(ch_level), 32'h00);
        check("midrst_pulse", 32'(ch_pulse), 32'h00);
        step(3);
        check("midrst_gflag", 32'(glitch_flag), 32'h00);
        reset = 1'b0;
        expect_ev(c_LAT, 8'h20, 1'b0);
        step(c_LAT);
        check("rel_level", 32'(ch_level), 32'h20);
        ch_in[5] = 1'b0;
        step(8);

        // 4-high/4-low toggling: every period accepted.
        for (int p = 0; p < 10; p++) begin
            ch_in[1] = 1'b1;
            expect_ev(c_LAT, 8'h02, 1'b0);
            step(4);
            ch_in[1] = 1'b0;
            step(4);
        end
        step(6);
        check("toggle44_gflag", 32'(glitch_flag), 32'h00);
        check("toggle44_level", 32'(ch_level), 32'h00);

        // 3-high/3-low toggling: never accepted, flagged as glitch.
        for (int p = 0; p < 10; p++) begin
            ch_in[1] = 1'b1;
            step(3);
            ch_in[1] = 1'b0;
            step(3);
        end
        step(8);
        check("toggle33_gflag", 32'(glitch_flag), 32'h02);
        check("toggle33_level", 32'(ch_level), 32'h00);

        step(10);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
